// File: rtl/wb_sram_slave_if.sv
// Wishbone classic-cycle bus bundle between a master and wb_sram_slave.
// Signal names follow the Wishbone signal names of the bus.
interface wb_sram_slave_if #(
  parameter int unsigned XLEN = 32
) ();
  logic [XLEN-1:0]   ADR;
  logic [XLEN-1:0]   DAT_W;
  logic [XLEN/8-1:0] SEL;
  logic              WE;
  logic              STB;
  logic              CYC;
  logic [XLEN-1:0]   DAT_R;
  logic              ACK;

  modport master (
    output ADR, DAT_W, SEL, WE, STB, CYC,
    input  DAT_R, ACK
  );

  modport slave (
    input  ADR, DAT_W, SEL, WE, STB, CYC,
    output DAT_R, ACK
  );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone classic-cycle SRAM responder: word-addressed single-port memory with byte-lane
// writes and a fixed number of wait states between request acceptance and the ACK cycle.
// Optional macro WB_SRAM_PRELOAD_EN adds parameter INIT_FILE; the memory starts uninitialised.
module wb_sram_slave #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH       = 1024,
  parameter int unsigned     WAIT_CYCLES = 0,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0
`ifdef WB_SRAM_PRELOAD_EN
  ,
  parameter string           INIT_FILE   = "program.hex"
`endif
) (
  input  logic            clk,
  input  logic            rst,
  wb_sram_slave_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = XLEN / 8;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] adr_q, adr_d;
  logic [XLEN-1:0] dat_w_q, dat_w_d;
  logic [NB-1:0]   sel_q, sel_d;
  logic            we_q, we_d;
  logic            ack_q, ack_d;
  logic [XLEN-1:0] dat_r_q, dat_r_d;

  logic [XLEN-1:0] mem [DEPTH];

  // Request view: live bus fields at acceptance (zero-wait case commits on that same edge),
  // latched copies afterwards.
  logic [XLEN-1:0] req_adr, req_dat_w, req_off;
  logic [NB-1:0]   req_sel;
  logic            req_we, in_range, commit, mem_we;
  logic [AW-1:0]   req_idx;

  // Select request fields and decode the word index and range check.
  always_comb begin
    if (state_q == StIdle) begin
      req_adr   = bus.ADR;
      req_dat_w = bus.DAT_W;
      req_sel   = bus.SEL;
      req_we    = bus.WE;
    end else begin
      req_adr   = adr_q;
      req_dat_w = dat_w_q;
      req_sel   = sel_q;
      req_we    = we_q;
    end
    req_off  = req_adr - BASE_ADDR;
    // Shift test instead of BASE_ADDR+DEPTH*4 so the upper bound cannot overflow.
    in_range = (req_adr >= BASE_ADDR) && ((req_off >> (AW + 2)) == '0);
    req_idx  = req_off[AW+1:2];
  end

  // Next-state logic: IDLE accepts, WAIT counts down or aborts, RESP is the single ACK cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_w_d = dat_w_q;
    sel_d   = sel_q;
    we_d    = we_q;
    dat_r_d = dat_r_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.STB && bus.CYC) begin
          adr_d   = bus.ADR;
          dat_w_d = bus.DAT_W;
          sel_d   = bus.SEL;
          we_d    = bus.WE;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
          end else begin
            state_d = StResp;
            commit  = 1'b1;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (!bus.CYC) begin
          state_d = StIdle;
        end else if (cnt_q <= 4'd1) begin
          state_d = StResp;
          commit  = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    ack_d = commit;
    if (commit && !req_we) begin
      dat_r_d = in_range ? mem[req_idx] : '0;
    end
    mem_we = commit && req_we && in_range;
  end

  // Control and response registers; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_w_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      dat_r_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_w_q <= dat_w_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      dat_r_q <= dat_r_d;
    end
  end

  // Byte-lane memory write on the edge entering RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (req_sel[i]) mem[req_idx][8*i +: 8] <= req_dat_w[8*i +: 8];
      end
    end
  end

  assign bus.ACK   = ack_q;
  assign bus.DAT_R = dat_r_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: two instances (zero wait states at base 0, three wait states at a
// non-zero base) driven by table vectors, random traffic against a word-array model, and
// hand-written fetch, abort and reset sequences.
module tb_wb_sram_slave;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam int unsigned DEPTH0 = 1024;
  localparam int unsigned W0 = 0;
  localparam logic [31:0] BASE1 = 32'h0000_4000;
  localparam int unsigned DEPTH1 = 256;
  localparam int unsigned W1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [2];
  logic [31:0] drv_adr [2];
  logic [31:0] drv_dat [2];
  logic [3:0]  drv_sel [2];
  logic        drv_we  [2];
  logic        drv_stb [2];
  logic        drv_cyc [2];
  logic        ack     [2];
  logic [31:0] dat_r   [2];

  wb_sram_slave_if #(.XLEN(32)) bus0 ();
  wb_sram_slave_if #(.XLEN(32)) bus1 ();

  assign bus0.ADR = drv_adr[0];
  assign bus0.DAT_W = drv_dat[0];
  assign bus0.SEL = drv_sel[0];
  assign bus0.WE = drv_we[0];
  assign bus0.STB = drv_stb[0];
  assign bus0.CYC = drv_cyc[0];
  assign ack[0] = bus0.ACK;
  assign dat_r[0] = bus0.DAT_R;
  assign bus1.ADR = drv_adr[1];
  assign bus1.DAT_W = drv_dat[1];
  assign bus1.SEL = drv_sel[1];
  assign bus1.WE = drv_we[1];
  assign bus1.STB = drv_stb[1];
  assign bus1.CYC = drv_cyc[1];
  assign ack[1] = bus1.ACK;
  assign dat_r[1] = bus1.DAT_R;

  wb_sram_slave #(.XLEN(32), .DEPTH(DEPTH0), .WAIT_CYCLES(W0), .BASE_ADDR(BASE0)) u_dut0 (
    .clk (clk),
    .rst (rst_v[0]),
    .bus (bus0)
  );

  wb_sram_slave #(.XLEN(32), .DEPTH(DEPTH1), .WAIT_CYCLES(W1), .BASE_ADDR(BASE1)) u_dut1 (
    .clk (clk),
    .rst (rst_v[1]),
    .bus (bus1)
  );

  int checks = 0;
  int errors = 0;

  // Reference memory: key = instance number in the upper half, word index in the lower half.
  logic [31:0] model_mem [longint];

  function automatic longint base_of(int d);
    return (d == 0) ? longint'(BASE0) : longint'(BASE1);
  endfunction

  function automatic longint depth_of(int d);
    return (d == 0) ? longint'(DEPTH0) : longint'(DEPTH1);
  endfunction

  function automatic int wait_of(int d);
    return (d == 0) ? int'(W0) : int'(W1);
  endfunction

  function automatic bit in_rng(int d, logic [31:0] a);
    longint la = longint'(a);
    return (la >= base_of(d)) && (la < base_of(d) + depth_of(d) * 4);
  endfunction

  function automatic longint key_of(int d, logic [31:0] a);
    return (longint'(d) << 32) | ((longint'(a) - base_of(d)) / 4);
  endfunction

  function automatic void model_write(int d, logic [31:0] a, logic [31:0] v, logic [3:0] s);
    logic [31:0] w;
    longint k;
    if (!in_rng(d, a)) return;
    k = key_of(d, a);
    w = model_mem.exists(k) ? model_mem[k] : 32'h0;
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = v[8*i +: 8];
    model_mem[k] = w;
  endfunction

  function automatic logic [31:0] model_read(int d, logic [31:0] a);
    longint k;
    if (!in_rng(d, a)) return 32'h0;
    k = key_of(d, a);
    return model_mem.exists(k) ? model_mem[k] : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus(input int d);
    drv_stb[d] = 1'b0;
    drv_cyc[d] = 1'b0;
    drv_we[d] = 1'b0;
  endtask

  // One complete transfer on instance d; returns read data and edges from drive to ACK.
  task automatic xfer(input int d, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      output logic [31:0] rdat, output int lat);
    drv_adr[d] = adr;
    drv_dat[d] = dat;
    drv_sel[d] = sel;
    drv_we[d] = we;
    drv_stb[d] = 1'b1;
    drv_cyc[d] = 1'b1;
    lat = 0;
    forever begin
      cycle();
      lat++;
      if (ack[d] || lat > 40) break;
    end
    rdat = dat_r[d];
    idle_bus(d);
    cycle();
    check("ack_one_cycle", {31'd0, ack[d]}, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [31:0] rd, a, v, exp_rd;
    logic [3:0] s;
    logic w;
    int lat, gap, nack, k;

    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1;
      drv_adr[d] = '0;
      drv_dat[d] = '0;
      drv_sel[d] = '0;
      idle_bus(d);
    end
    repeat (3) cycle();
    for (int d = 0; d < 2; d++) begin
      check("reset_ack", {31'd0, ack[d]}, 32'd0);
      check("reset_dat_r", dat_r[d], 32'd0);
      rst_v[d] = 1'b0;
    end
    cycle();

    // Directed vectors on the zero-wait instance.
    tbl[0] = '{1'b1, 32'h10,   32'hDEAD_BEEF, 4'hF, 32'h0};
    tbl[1] = '{1'b0, 32'h10,   32'h0,         4'hF, 32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 32'h10,   32'h0000_00AA, 4'h1, 32'h0};
    tbl[3] = '{1'b0, 32'h10,   32'h0,         4'hF, 32'hDEAD_BEAA};
    tbl[4] = '{1'b1, 32'h10,   32'h1100_0000, 4'h8, 32'h0};
    tbl[5] = '{1'b0, 32'h13,   32'h0,         4'h0, 32'h11AD_BEAA};
    tbl[6] = '{1'b0, 32'h1000, 32'h0,         4'hF, 32'h0};
    tbl[7] = '{1'b1, 32'h0,    32'hCAFE_F00D, 4'hF, 32'h0};
    tbl[8] = '{1'b1, 32'h1000, 32'h1234_5678, 4'hF, 32'h0};
    tbl[9] = '{1'b0, 32'h0,    32'h0,         4'hF, 32'hCAFE_F00D};
    for (int i = 0; i < 10; i++) begin
      xfer(0, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'(W0 + 1));
      if (tbl[i].we) model_write(0, tbl[i].adr, tbl[i].dat, tbl[i].sel);
      else check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
    end

    // Random traffic on both instances against the model.
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 16; j++) begin
        a = 32'(base_of(d)) + 32'(4 * j);
        v = $urandom;
        xfer(d, 1'b1, a, v, 4'hF, rd, lat);
        model_write(d, a, v, 4'hF);
      end
      for (int j = 0; j < 120; j++) begin
        k = $urandom_range(0, 11);
        a = 32'(base_of(d)) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        if (k == 0) a = 32'(base_of(d) + depth_of(d) * 4) + 32'(4 * $urandom_range(0, 7));
        if (k == 1) a = 32'(base_of(d)) - 32'd4;
        if (k == 2) begin
          // Strobe without cycle must be ignored.
          drv_stb[d] = 1'b1;
          drv_cyc[d] = 1'b0;
          nack = 0;
          repeat (3) begin
            cycle();
            if (ack[d]) nack++;
          end
          idle_bus(d);
          check("stb_without_cyc", nack, 0);
        end
        w = 1'($urandom_range(0, 1));
        v = $urandom;
        s = 4'($urandom_range(0, 15));
        exp_rd = model_read(d, a);
        xfer(d, w, a, v, s, rd, lat);
        check($sformatf("rand%0d_latency", d), lat, 32'(wait_of(d) + 1));
        if (w) model_write(d, a, v, s);
        else check($sformatf("rand%0d_rdata @%h", d, a), rd, exp_rd);
        repeat ($urandom_range(0, 2)) cycle();
      end
    end

    // Fetch pattern on the wait-state instance: STB&CYC held across three sequential reads.
    for (int j = 0; j < 3; j++) begin
      a = BASE1 + 32'(4 * j);
      v = 32'h1111_0000 + 32'(j);
      xfer(1, 1'b1, a, v, 4'hF, rd, lat);
      model_write(1, a, v, 4'hF);
    end
    drv_adr[1] = BASE1;
    drv_we[1] = 1'b0;
    drv_stb[1] = 1'b1;
    drv_cyc[1] = 1'b1;
    gap = 0;
    k = 0;
    for (int c = 0; c < 40 && k < 3; c++) begin
      cycle();
      gap++;
      if (ack[1]) begin
        check($sformatf("fetch%0d_spacing", k), gap, (k == 0) ? W1 + 1 : W1 + 2);
        check($sformatf("fetch%0d_rdata", k), dat_r[1], model_read(1, drv_adr[1]));
        gap = 0;
        k++;
        if (k == 3) idle_bus(1);
        else drv_adr[1] = drv_adr[1] + 32'd4;
      end
    end
    check("fetch_ack_count", k, 3);
    idle_bus(1);
    cycle();
    check("fetch_ack_end", {31'd0, ack[1]}, 32'd0);

    // Abort: drop CYC while in WAIT; neither ACK nor write may happen.
    a = BASE1 + 32'h20;
    exp_rd = model_read(1, a);
    drv_adr[1] = a;
    drv_dat[1] = ~exp_rd;
    drv_sel[1] = 4'hF;
    drv_we[1] = 1'b1;
    drv_stb[1] = 1'b1;
    drv_cyc[1] = 1'b1;
    cycle();
    cycle();
    idle_bus(1);
    nack = 0;
    repeat (8) begin
      cycle();
      if (ack[1]) nack++;
    end
    check("abort_no_ack", nack, 0);
    xfer(1, 1'b0, a, 32'h0, 4'hF, rd, lat);
    check("abort_latency", lat, 32'(W1 + 1));
    check("abort_old_data", rd, exp_rd);

    // Reset during WAIT drops the write; memory survives.
    xfer(1, 1'b0, BASE1, 32'h0, 4'hF, rd, lat);
    check("pre_reset_rdata", rd, model_read(1, BASE1));
    a = BASE1 + 32'h30;
    exp_rd = model_read(1, a);
    drv_adr[1] = a;
    drv_dat[1] = ~exp_rd;
    drv_sel[1] = 4'hF;
    drv_we[1] = 1'b1;
    drv_stb[1] = 1'b1;
    drv_cyc[1] = 1'b1;
    cycle();
    rst_v[1] = 1'b1;
    idle_bus(1);
    cycle();
    check("midop_reset_ack", {31'd0, ack[1]}, 32'd0);
    check("midop_reset_dat_r", dat_r[1], 32'd0);
    rst_v[1] = 1'b0;
    nack = 0;
    repeat (6) begin
      cycle();
      if (ack[1]) nack++;
    end
    check("midop_reset_no_late_ack", nack, 0);
    xfer(1, 1'b0, a, 32'h0, 4'hF, rd, lat);
    check("post_reset_latency", lat, 32'(W1 + 1));
    check("post_reset_dropped_write", rd, exp_rd);
    xfer(1, 1'b0, BASE1 + 32'h4, 32'h0, 4'hF, rd, lat);
    check("post_reset_mem_intact", rd, model_read(1, BASE1 + 32'h4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
